// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control and the ALU control decoder.
// The addi path in mc_control is compiled in only when MC_CTRL_ADDI_EN is defined.
package mc_pkg;

  localparam logic [3:0] S_IF      = 4'd0;
  localparam logic [3:0] S_ID      = 4'd1;
  localparam logic [3:0] S_MEM_ADR = 4'd2;
  localparam logic [3:0] S_MEM_RD  = 4'd3;
  localparam logic [3:0] S_MEM_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR  = 4'd5;
  localparam logic [3:0] S_R_EX    = 4'd6;
  localparam logic [3:0] S_R_WB    = 4'd7;
  localparam logic [3:0] S_BEQ     = 4'd8;
  localparam logic [3:0] S_J       = 4'd9;
  localparam logic [3:0] S_ADDI_EX = 4'd10;
  localparam logic [3:0] S_ADDI_WB = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ASB_B       = 2'b00;
  localparam logic [1:0] ASB_FOUR    = 2'b01;
  localparam logic [1:0] ASB_IMM     = 2'b10;
  localparam logic [1:0] ASB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

endpackage

// File: rtl/mc_control_outdec.sv
// Combinational decode of FSM state (+ mem_ready for the IF/MEM_WR Mealy terms)
// into datapath controls. ADDI states decode only under MC_CTRL_ADDI_EN.
module mc_outdec
  import mc_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_IF: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = ASB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_ID: begin
        ctrl_o.alu_src_b = ASB_IMM_SL2;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
`ifdef MC_CTRL_ADDI_EN
      S_MEM_ADR, S_ADDI_EX: begin
`else
      S_MEM_ADR: begin
`endif
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.retire    = mem_ready_i;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.retire     = 1'b1;
      end
      S_R_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = ASB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.retire    = 1'b1;
      end
`endif
      S_BEQ: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCS_ALUOUT;
        ctrl_o.retire        = 1'b1;
      end
      S_J: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCS_JUMP;
        ctrl_o.retire    = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control: state register + next-state logic; outputs via mc_outdec.
// Define MC_CTRL_ADDI_EN to compile in the addi path (otherwise addi decodes as illegal).
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSource,
  output logic [1:0] ALUop,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  logic [3:0] state_q, state_d;
  logic       illegal_d;
  ctrl_t      ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = S_IF;
    illegal_d = 1'b0;
    case (state_q)
      S_IF:     state_d = mem_ready ? S_ID : S_IF;
      S_ID: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_R_EX;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_J;
`ifdef MC_CTRL_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default:      illegal_d = 1'b1;
        endcase
      end
      // opcode is still IR-held here; anything but lw/sw cannot reach MEM_ADR
      S_MEM_ADR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
      end
      S_MEM_RD:  state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:  state_d = mem_ready ? S_IF : S_MEM_WR;
      S_R_EX:    state_d = S_R_WB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDI_EX: state_d = S_ADDI_WB;
`endif
      default:   state_d = S_IF;
    endcase
  end

  mc_outdec u_outdec (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.i_or_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign PCSource    = ctrl.pc_source;
  assign ALUop       = ctrl.alu_op;
  assign retire      = ctrl.retire;
  assign illegal     = illegal_d;
  assign state       = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Randomized bench for mc_control: per-instruction expected state/control traces
// built from the instruction-level rules, with random memory wait cycles.
module tb_mc_control;

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                         BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic       clk = 1'b0, rst_n, mem_ready;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic       RegWrite, RegDst, ALUSrcA, retire, illegal;
  logic [1:0] ALUSrcB, PCSource, ALUop;
  logic [3:0] state;

  mc_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
    .ALUop(ALUop), .state(state), .retire(retire), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  wire [17:0] ctrl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                          IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, PCSource,
                          ALUop, retire, illegal};

  function automatic bit legal(input logic [5:0] op);
    bit ok;
    ok = (op == R) || (op == LW) || (op == SW) || (op == BEQ) || (op == JMP);
`ifdef MC_CTRL_ADDI_EN
    ok = ok || (op == ADDI);
`endif
    return ok;
  endfunction

  // Expected controls from the per-step output table.
  function automatic logic [17:0] exp_ctrl(input int st, input logic mr, input logic [5:0] op);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, ret, ill;
    logic [1:0] asb, pcs, aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, ret, ill} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 2'b00;
    case (st)
      0:     begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
      1:     begin asb = 2'b11; ill = !legal(op); end
      2, 10: begin asa = 1; asb = 2'b10; end
      3:     begin mrd = 1; iord = 1; end
      4:     begin rw = 1; m2r = 1; ret = 1; end
      5:     begin mwr = 1; iord = 1; ret = mr; end
      6:     begin asa = 1; aop = 2'b10; end
      7:     begin rw = 1; rdst = 1; ret = 1; end
      8:     begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; ret = 1; end
      9:     begin pcw = 1; pcs = 2'b10; ret = 1; end
      11:    begin rw = 1; ret = 1; end
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, rw, rdst, asa, asb, pcs, aop, ret, ill};
  endfunction

  typedef struct { int st; logic mr; } step_t;
  step_t q[$];

  task automatic add_wait(input int st, input int waits);
    step_t s;
    s.st = st;
    for (int i = 0; i < waits; i++) begin s.mr = 1'b0; q.push_back(s); end
    s.mr = 1'b1; q.push_back(s);
  endtask

  task automatic add_plain(input int st);
    step_t s;
    s.st = st; s.mr = 1'($urandom_range(0, 1));
    q.push_back(s);
  endtask

  // One instruction from IF back to IF; negative wait counts pick random ones.
  task automatic run_instr(input logic [5:0] op, input int w_if, input int w_mem);
    int n_ret = 0, n_ill = 0, wi, wm;
    wi = (w_if  < 0) ? int'($urandom_range(0, 2)) : w_if;
    wm = (w_mem < 0) ? int'($urandom_range(0, 2)) : w_mem;
    q.delete();
    add_wait(0, wi);
    add_plain(1);
    if (legal(op)) begin
      case (op)
        LW:      begin add_plain(2); add_wait(3, wm); add_plain(4); end
        SW:      begin add_plain(2); add_wait(5, wm); end
        R:       begin add_plain(6); add_plain(7); end
        BEQ:     add_plain(8);
        JMP:     add_plain(9);
        default: begin add_plain(10); add_plain(11); end
      endcase
    end
    opcode = op;
    foreach (q[i]) begin
      mem_ready = q[i].mr;
      @(negedge clk);
      chk($sformatf("state op=%b step%0d", op, i), 32'(state), 32'(q[i].st));
      chk($sformatf("ctrl op=%b st=%0d", op, q[i].st), 32'(ctrl_obs),
          32'(exp_ctrl(q[i].st, q[i].mr, op)));
      chk("memrd_memwr_excl", 32'(MemRead & MemWrite), 32'd0);
      n_ret += int'(retire);
      n_ill += int'(illegal);
      @(posedge clk); #1;
    end
    chk($sformatf("back_to_IF op=%b", op), 32'(state), 32'd0);
    chk($sformatf("retire_cnt op=%b", op), 32'(n_ret), legal(op) ? 32'd1 : 32'd0);
    chk($sformatf("illegal_cnt op=%b", op), 32'(n_ill), legal(op) ? 32'd0 : 32'd1);
  endtask

  initial begin
    logic [5:0] op;
    rst_n = 1'b0; mem_ready = 1'b1; opcode = '0;
    #3;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_ctrl_ready", 32'(ctrl_obs), 32'(exp_ctrl(0, 1'b1, 6'd0)));
    mem_ready = 1'b0; #1;
    chk("rst_ctrl_idle", 32'(ctrl_obs), 32'(exp_ctrl(0, 1'b0, 6'd0)));
    #8 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed scenarios
    run_instr(LW, 0, 0);
    run_instr(R, 2, 0);
    run_instr(BEQ, 0, 0);
    run_instr(JMP, 0, 0);
    run_instr(SW, 0, 1);
    run_instr(6'b111111, 0, 0);
    run_instr(ADDI, 0, 0);

    // Reset mid-instruction while in MEM_RD
    opcode = LW; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_rst_memrd", 32'(state), 32'd3);
    mem_ready = 1'b0; #2;
    rst_n = 1'b0; #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_ctrl", 32'(ctrl_obs), 32'(exp_ctrl(0, 1'b0, LW)));
    @(posedge clk); #1;
    chk("held_rst_state", 32'(state), 32'd0);
    chk("held_rst_wr", 32'({MemWrite, RegWrite, retire}), 32'd0);
    rst_n = 1'b1;
    run_instr(LW, -1, -1);

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 6))
        0: op = R;
        1: op = LW;
        2: op = SW;
        3: op = BEQ;
        4: op = JMP;
        5: op = ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (legal(op)) op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr(op, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle main control unit for the MIPS datapath: a Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and write-back steps. It is the producer of the 2-bit `ALUop` code consumed by the ALU control decoder: 00 = add, 01 = subtract, 10 = use `funct`. It also drives every datapath enable and multiplexer select. It sits between the instruction register (opcode source) and the datapath/memory.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `opcode` in 6: `IR[31:26]`; held stable by the datapath after IF.
- `mem_ready` in 1: memory completes the current access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `MemtoReg`, `IRWrite`, `RegWrite`, `RegDst`, `ALUSrcA` out 1 each: datapath controls.
- `ALUSrcB` out 2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left by 2.
- `PCSource` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `ALUop` out 2: 00 = add, 01 = subtract, 10 = `funct`.
- `state` out 4: current state, for debug.
- `retire` out 1: high in the final cycle of every completed instruction.
- `illegal` out 1: one-cycle pulse in ID on an unsupported opcode.

## Operation
- State encoding: IF=0, ID=1, MEM_ADR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BEQ=8, J=9, ADDI_EX=10, ADDI_WB=11. Codes 12–15 are unused and return to IF.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- Transitions:
  - IF→ID when `mem_ready`; otherwise stay in IF.
  - ID → MEM_ADR for lw/sw, R_EX for R, BEQ for beq, J for j, ADDI_EX for addi. Any other opcode → IF with `illegal` high.
  - MEM_ADR → MEM_RD for lw, MEM_WR for sw.
  - MEM_RD→MEM_WB when `mem_ready`; otherwise stay in MEM_RD.
  - MEM_WR→IF when `mem_ready`; otherwise stay in MEM_WR.
  - R_EX→R_WB, ADDI_EX→ADDI_WB.
  - MEM_WB, R_WB, BEQ, J, ADDI_WB → IF.
- Outputs per state. Any signal not listed is 0.
  - IF: MemRead=1, ALUSrcB=01. `IRWrite` and `PCWrite` equal `mem_ready` (the only Mealy terms).
  - ID: ALUSrcB=11, ALUop=00 (branch target computation).
  - MEM_ADR and ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUop=00.
  - MEM_RD: MemRead=1, IorD=1.
  - MEM_WR: MemWrite=1, IorD=1, retire=`mem_ready`.
  - MEM_WB: RegWrite=1, MemtoReg=1, retire=1.
  - R_EX: ALUSrcA=1, ALUSrcB=00, ALUop=10.
  - R_WB and ADDI_WB: RegWrite=1, plus RegDst=1 for R_WB only; retire=1.
  - BEQ: ALUSrcA=1, ALUop=01, PCWriteCond=1, PCSource=01, retire=1.
  - J: PCWrite=1, PCSource=10, retire=1.
- MemRead and MemWrite are never high in the same cycle.
- `opcode` is sampled only in ID and MEM_ADR.

## Timing
- Reset: `state`=IF immediately and asynchronously. While reset is held, outputs take the IF values (MemRead=1, ALUSrcB=01, all else 0; IRWrite/PCWrite follow `mem_ready`).
- Reset asserted mid-instruction aborts it. No retire and no write enable survive the reset.
- Cycles per instruction with zero-wait memory (`mem_ready`=1): lw 5, sw 4, R 4, addi 4, beq 3, j 3, illegal 2.
- Each low cycle of `mem_ready` in IF, MEM_RD or MEM_WR adds exactly one cycle. Control outputs stay constant while waiting.
- `illegal` is asserted only in the ID cycle; `retire` is not asserted for an illegal opcode.

## Configuration
- Macro `MC_CTRL_ADDI_EN`.
- Defined: the addi path (ADDI_EX, ADDI_WB) is compiled in.
- Undefined: the addi states are absent, and opcode 001000 is handled as illegal in ID (pulse, return to IF). All other behaviour is identical.

## Structure
- Shared package `mc_pkg` holds:
  - state localparams (4-bit);
  - opcode constants;
  - ALUop encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10);
  - ALUSrcB and PCSource encodings.
  The ALU control decoder imports the same ALUop constants.
- One sub-module: `mc_outdec`, a purely combinational decode from `state` + `mem_ready` to all control outputs. The top level holds the state register and next-state logic.

## Test plan
- Reset, then lw with `mem_ready`=1: states 0,1,2,3,4. MemtoReg=RegWrite=1 in cycle 5; `retire` high only in cycle 5.
- R-type with `mem_ready` low for 2 cycles in IF: IF held 3 cycles with IRWrite=0 then 1. ALUop=10 in R_EX; R_WB has RegDst=1.
- beq then j: BEQ has ALUop=01, PCWriteCond=1, PCSource=01. J has PCWrite=1, PCSource=10. Each takes 3 cycles.
- sw with `mem_ready` low for 1 cycle in MEM_WR: MemWrite=1 for 2 cycles, `retire` only in the second.
- Opcode 111111: `illegal` pulses in ID, next state IF, no RegWrite/MemWrite/retire. Repeat with 001000 with `MC_CTRL_ADDI_EN` undefined: same result. With it defined: 4-cycle addi, RegDst=0.
- Assert `rst_n`=0 in MEM_RD: `state`=0 immediately and MemWrite/RegWrite stay 0. After release, fetch resumes normally.
